sid_mix_dac: RTL

//  Parametrised mixer + dual-line SPI DAC driver for the sound subsystem. Takes NCH unsigned

---
 rtl/sid_mix_pkg.sv | 43 ++++
 rtl/sid_mix_dac_shift_out.sv | 98 +++++++++
 rtl/sid_mix_dac.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sid_mix_pkg.sv
// Shared types, pan encodings, register map offsets and sizing helpers
// for the sid_mix_dac mixer/DAC driver.
package sid_mix_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MIX,
    S_SAT,
    S_SHIFT,
    S_LATCH
  } mix_state_t;

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_RUN,
    SH_LE
  } shift_state_t;

  localparam logic [1:0] PAN_OFF  = 2'b00;
  localparam logic [1:0] PAN_L    = 2'b01;
  localparam logic [1:0] PAN_R    = 2'b10;
  localparam logic [1:0] PAN_BOTH = 2'b11;

  localparam int CH_BASE = 0;

  function automatic int ctrl_ofs(int nch);
    return CH_BASE + nch;
  endfunction

  function automatic int stat_ofs(int nch);
    return CH_BASE + nch + 1;
  endfunction

  function automatic int last_ofs(int nch);
    return CH_BASE + nch + 2;
  endfunction

  // Room for NCH products of a signed SW-bit sample and a 4-bit volume.
  function automatic int acc_width(int sw, int nch);
    return sw + 5 + $clog2(nch);
  endfunction

endpackage

// File: rtl/sid_mix_dac_shift_out.sv
// Dual-line serial DAC shifter: divided SPI clock, MSB-first data on both
// lines, then a one-half-period latch-enable pulse; start/done handshake.
module dac_shift_out
  import sid_mix_pkg::*;
#(
  parameter int DAC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       div,
  input  logic [DAC_W-1:0] word_l,
  input  logic [DAC_W-1:0] word_r,
  output logic             dac_clk,
  output logic             dac_le,
  output logic             dac_dat_l,
  output logic             dac_dat_r,
  output logic             done
);

  localparam int BW = $clog2(DAC_W + 1);

  shift_state_t     st;
  logic [DAC_W-1:0] sr_l, sr_r;
  logic [3:0]       hcnt;
  logic [3:0]       div_q;
  logic [BW-1:0]    bit_cnt;

  // The shift registers are cleared outside a frame, so both data lines idle low.
  assign dac_dat_l = sr_l[DAC_W-1];
  assign dac_dat_r = sr_r[DAC_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= SH_IDLE;
      sr_l    <= '0;
      sr_r    <= '0;
      hcnt    <= '0;
      div_q   <= '0;
      bit_cnt <= '0;
      dac_clk <= 1'b0;
      dac_le  <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      done <= 1'b0;
      case (st)
        SH_IDLE: begin
          if (start) begin
            sr_l    <= word_l;
            sr_r    <= word_r;
            hcnt    <= '0;
            div_q   <= div;
            bit_cnt <= '0;
            dac_clk <= 1'b0;
            st      <= SH_RUN;
          end
        end
        SH_RUN: begin
          if (hcnt == div_q) begin
            // div is re-sampled only at half-period boundaries.
            hcnt  <= '0;
            div_q <= div;
            if (!dac_clk) begin
              dac_clk <= 1'b1;
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              dac_clk <= 1'b0;
              if (bit_cnt == BW'(DAC_W)) begin
                sr_l   <= '0;
                sr_r   <= '0;
                dac_le <= 1'b1;
                st     <= SH_LE;
              end else begin
                sr_l <= {sr_l[DAC_W-2:0], 1'b0};
                sr_r <= {sr_r[DAC_W-2:0], 1'b0};
              end
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        SH_LE: begin
          if (hcnt == div_q) begin
            hcnt   <= '0;
            dac_le <= 1'b0;
            done   <= 1'b1;
            st     <= SH_IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: st <= SH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sid_mix_dac.sv
// NCH-voice mixer with per-channel volume/pan, saturation to DAC_W bits and a
// dual serial DAC output; configured through the peripheral byte bus.
module sid_mix_dac
  import sid_mix_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int SW     = 12,
  parameter int DAC_W  = 12,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        bus_in,
  output logic [7:0]        bus_out,
  input  logic              bus_cyc,
  input  logic              bus_we,
  input  logic [NCH*SW-1:0] samples,
  input  logic              sample_ready,
  output logic              dac_clk,
  output logic              dac_le,
  output logic              dac_dat_l,
  output logic              dac_dat_r,
  output logic              busy
);

  localparam int AW       = acc_width(SW, NCH);
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SH       = SW + 4 - DAC_W;
  localparam int CTRL_OFS = ctrl_ofs(NCH);
  localparam int STAT_OFS = stat_ofs(NCH);
  localparam int LAST_OFS = last_ofs(NCH);
  localparam logic signed [AW-1:0] W_MAX = AW'((2 ** (DAC_W - 1)) - 1);
  localparam logic signed [AW-1:0] W_MIN = ~W_MAX;

  mix_state_t            state;
  logic [5:0]            ch_cfg [NCH];
  logic                  enable;
  logic [3:0]            div;
  logic                  drop;
  logic [7:0]            last_word;
  logic [NCH*SW-1:0]     samp_q;
  logic [CHW-1:0]        ch;
  logic signed [AW-1:0]  acc_l, acc_r;

  logic                  bus_wr, stat_wr, drop_evt;
  logic [7:0]            rd_data;
  logic                  unused_bus_bits;

  assign bus_wr   = bus_cyc && bus_we;
  assign stat_wr  = bus_wr && (addr == ADDR_W'(STAT_OFS));
  assign drop_evt = sample_ready && enable && (state != S_IDLE);
  assign unused_bus_bits = ^bus_in[7:6];

  // Mixer datapath: offset-binary sample to signed, scaled by the channel volume.
  logic [SW-1:0]          cur_samp;
  logic [5:0]             cur_cfg;
  logic signed [SW-1:0]   cur_s;
  logic signed [SW+4:0]   cur_p;
  logic signed [AW-1:0]   cur_p_ext;
  logic                   add_l, add_r;

  assign cur_samp  = samp_q[ch*SW +: SW];
  assign cur_cfg   = ch_cfg[ch];
  assign cur_s     = {~cur_samp[SW-1], cur_samp[SW-2:0]};
  assign cur_p     = (SW+5)'(cur_s) * (SW+5)'($signed({1'b0, cur_cfg[3:0]}));
  assign cur_p_ext = AW'(cur_p);

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    add_l = 1'b0;
    add_r = 1'b0;
    case (cur_cfg[5:4])
      PAN_OFF:  ;
      PAN_L:    add_l = 1'b1;
      PAN_R:    add_r = 1'b1;
      PAN_BOTH: begin
        add_l = 1'b1;
        add_r = 1'b1;
      end
      default:  ;
    endcase
  end

  function automatic logic [DAC_W-1:0] sat_word(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] w;
    w = acc >>> SH;
    if (w > W_MAX)      sat_word = {DAC_W{1'b1}};
    else if (w < W_MIN) sat_word = '0;
    else                sat_word = {~w[DAC_W-1], w[DAC_W-2:0]};
  endfunction

  logic [DAC_W-1:0] word_l, word_r;
  logic             shift_start, shift_done;

  assign word_l      = sat_word(acc_l);
  assign word_r      = sat_word(acc_r);
  assign shift_start = (state == S_SAT);

  dac_shift_out #(.DAC_W(DAC_W)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .start     (shift_start),
    .div       (div),
    .word_l    (word_l),
    .word_r    (word_r),
    .dac_clk   (dac_clk),
    .dac_le    (dac_le),
    .dac_dat_l (dac_dat_l),
    .dac_dat_r (dac_dat_r),
    .done      (shift_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      ch        <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      samp_q    <= '0;
      last_word <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sample_ready && enable) begin
            samp_q <= samples;
            acc_l  <= '0;
            acc_r  <= '0;
            ch     <= '0;
            busy   <= 1'b1;
            state  <= S_MIX;
          end
        end
        S_MIX: begin
          if (add_l) acc_l <= acc_l + cur_p_ext;
          if (add_r) acc_r <= acc_r + cur_p_ext;
          ch <= ch + 1'b1;
          if (ch == CHW'(NCH - 1)) state <= S_SAT;
        end
        S_SAT: begin
          last_word <= word_l[DAC_W-1 -: 8];
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (dac_le) state <= S_LATCH;
        end
        S_LATCH: begin
          if (shift_done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++)
      if (addr == ADDR_W'(CH_BASE + i)) rd_data = {2'b00, ch_cfg[i]};
    if (addr == ADDR_W'(CTRL_OFS)) rd_data = {3'b000, div, enable};
    if (addr == ADDR_W'(STAT_OFS)) rd_data = {6'b0, drop, busy};
    if (addr == ADDR_W'(LAST_OFS)) rd_data = last_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the config array is reset as well; every register must read 0 after reset.
      for (int i = 0; i < NCH; i++) ch_cfg[i] <= '0;
      enable  <= 1'b0;
      div     <= '0;
      drop    <= 1'b0;
      bus_out <= '0;
    end else begin
      if (bus_wr) begin
        for (int i = 0; i < NCH; i++)
          if (addr == ADDR_W'(CH_BASE + i)) ch_cfg[i] <= bus_in[5:0];
        if (addr == ADDR_W'(CTRL_OFS)) begin
          enable <= bus_in[0];
          div    <= bus_in[4:1];
        end
      end
      // A drop in the same cycle as a STAT write keeps the flag set.
      if (drop_evt)     drop <= 1'b1;
      else if (stat_wr) drop <= 1'b0;
      if (bus_cyc) bus_out <= rd_data;
    end
  end

endmodule
